event_recorder: RTL and testbench

EVENT_RECORDER -- requirements
Module: event_recorder

---
 rtl/event_recorder_pkg.sv | 33 +++
 rtl/event_recorder_if.sv | 26 ++
 rtl/event_fifo.sv | 59 +++++
 rtl/event_recorder.sv | 106 ++++++++++
 tb/tb_event_recorder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/event_recorder_pkg.sv
// Shared defaults and record layout for the event recorder.
// A record is {mask, tot_long, tot_short, timestamp, index}, MSB first.
package event_recorder_pkg;

  localparam int NCH_DEF   = 2;
  localparam int TOT_W_DEF = 16;
  localparam int TS_W_DEF  = 32;
  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 256;
  localparam int IDX_W     = 16;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic int rec_w(input int nch, input int tot_w, input int ts_w);
    return nch + 2 * tot_w + ts_w + IDX_W;
  endfunction

  localparam int IDX_LSB = 0;
  localparam int TS_LSB  = IDX_W;

  function automatic int tot_short_lsb(input int ts_w);
    return IDX_W + ts_w;
  endfunction

  function automatic int tot_long_lsb(input int tot_w, input int ts_w);
    return IDX_W + ts_w + tot_w;
  endfunction

  function automatic int mask_lsb(input int tot_w, input int ts_w);
    return IDX_W + ts_w + 2 * tot_w;
  endfunction

endpackage

// File: rtl/event_recorder_if.sv
// Read-side bus of the event recorder: request, returned record and FIFO status.
interface event_recorder_if
  import event_recorder_pkg::*;
#(
  parameter int REC_W = rec_w(NCH_DEF, TOT_W_DEF, TS_W_DEF),
  parameter int LVL_W = $clog2(DEPTH_DEF) + 1
);

  logic             RD_EN;
  logic [REC_W-1:0] RD_DATA;
  logic             RD_VALID;
  logic             EMPTY;
  logic             FULL;
  logic [LVL_W-1:0] LEVEL;

  modport master (
    output RD_EN,
    input  RD_DATA, RD_VALID, EMPTY, FULL, LEVEL
  );

  modport slave (
    input  RD_EN,
    output RD_DATA, RD_VALID, EMPTY, FULL, LEVEL
  );

endinterface

// File: rtl/event_fifo.sv
// Synchronous record FIFO: block-RAM storage with a registered, read-first output.
module event_fifo #(
  parameter int W     = 82,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_rd;
  logic          do_wr;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign do_rd = rd_en & ~empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
      if (do_wr) wptr <= wptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/event_recorder.sv
// Event recorder: detects trigger edges, timestamps and buffers event records,
// and keeps saturating live/dead/trigger/drop/singles metrics.
module event_recorder
  import event_recorder_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int TOT_W = TOT_W_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int REC_W = rec_w(NCH, TOT_W, TS_W)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NCH-1:0]       SIGNAL,
  input  logic                 TRIGGER_ACTIVE,
  input  logic                 LIVE_ACQUISITION,
  input  logic [TOT_W-1:0]     TOT_SHORT,
  input  logic [TOT_W-1:0]     TOT_LONG,
  input  logic                 CLEAR_COUNTERS,
  event_recorder_if.slave      rd,
  output logic [CNT_W-1:0]     NTRIGGERS,
  output logic [CNT_W-1:0]     LIVE_TIME,
  output logic [CNT_W-1:0]     DEAD_TIME,
  output logic [CNT_W-1:0]     NDROPPED,
  output logic [NCH*CNT_W-1:0] NSINGLES
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             trig_p0;
  logic             vld_p1;
  logic [NCH-1:0]   sig_p0;
  logic [NCH-1:0]   rise;
  logic [TS_W-1:0]  ts_cnt;
  idx_t             evt_idx;
  logic [REC_W-1:0] rec;
  logic             wr_en;
  logic             drop;
  logic [CNT_W-1:0] singles [NCH];

  // Stage p0: previous samples for edge detection; p1: one-cycle trigger strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      trig_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      sig_p0  <= '0;
      ts_cnt  <= '0;
      evt_idx <= '0;
    end else begin
      trig_p0 <= TRIGGER_ACTIVE;
      vld_p1  <= TRIGGER_ACTIVE & ~trig_p0;
      sig_p0  <= SIGNAL;
      ts_cnt  <= ts_cnt + TS_W'(1);
      if (vld_p1) evt_idx <= evt_idx + IDX_W'(1);
    end
  end

  assign rise  = SIGNAL & ~sig_p0;
  assign rec   = {SIGNAL, TOT_LONG, TOT_SHORT, ts_cnt, evt_idx};
  assign wr_en = vld_p1 & (~rd.FULL | rd.RD_EN);
  assign drop  = vld_p1 & ~wr_en;

  // Clear has priority over any increment landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET || CLEAR_COUNTERS) begin
      NTRIGGERS <= '0;
      LIVE_TIME <= '0;
      DEAD_TIME <= '0;
      NDROPPED  <= '0;
      for (int i = 0; i < NCH; i++) singles[i] <= '0;
    end else begin
      if (vld_p1) NTRIGGERS <= sat_inc(NTRIGGERS);
      if (drop)   NDROPPED  <= sat_inc(NDROPPED);
      if (LIVE_ACQUISITION) LIVE_TIME <= sat_inc(LIVE_TIME);
      else                  DEAD_TIME <= sat_inc(DEAD_TIME);
      for (int i = 0; i < NCH; i++) begin
        if (rise[i]) singles[i] <= sat_inc(singles[i]);
      end
    end
  end

  always_comb begin
    NSINGLES = '0;
    for (int i = 0; i < NCH; i++) NSINGLES[i*CNT_W +: CNT_W] = singles[i];
  end

  event_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .wr_en    (wr_en),
    .wr_data  (rec),
    .rd_en    (rd.RD_EN),
    .rd_data  (rd.RD_DATA),
    .rd_valid (rd.RD_VALID),
    .empty    (rd.EMPTY),
    .full     (rd.FULL),
    .level    (rd.LEVEL)
  );

endmodule

// File: tb/tb_event_recorder.sv
// Directed bench for event_recorder: a 32-bit-counter instance and a 4-bit
// counter/timestamp instance share all inputs; both use a 4-deep FIFO.
module tb_event_recorder;

  logic        CLK = 1'b0;
  logic        RESET, TA, LIVE, CLR, rd_en;
  logic [1:0]  SIG;
  logic [15:0] TS, TL;

  logic [31:0] ntrig1, live1, dead1, ndrop1;
  logic [63:0] sing1;
  logic [3:0]  ntrig2, live2, dead2, ndrop2;
  logic [7:0]  sing2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  event_recorder_if #(.REC_W(82), .LVL_W(3)) rd1 ();
  event_recorder_if #(.REC_W(54), .LVL_W(3)) rd2 ();
  assign rd1.RD_EN = rd_en;
  assign rd2.RD_EN = rd_en;

  event_recorder #(.NCH(2), .TOT_W(16), .TS_W(32), .CNT_W(32), .DEPTH(4)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .SIGNAL(SIG), .TRIGGER_ACTIVE(TA),
    .LIVE_ACQUISITION(LIVE), .TOT_SHORT(TS), .TOT_LONG(TL),
    .CLEAR_COUNTERS(CLR), .rd(rd1), .NTRIGGERS(ntrig1), .LIVE_TIME(live1),
    .DEAD_TIME(dead1), .NDROPPED(ndrop1), .NSINGLES(sing1)
  );

  event_recorder #(.NCH(2), .TOT_W(16), .TS_W(4), .CNT_W(4), .DEPTH(4)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .SIGNAL(SIG), .TRIGGER_ACTIVE(TA),
    .LIVE_ACQUISITION(LIVE), .TOT_SHORT(TS), .TOT_LONG(TL),
    .CLEAR_COUNTERS(CLR), .rd(rd2), .NTRIGGERS(ntrig2), .LIVE_TIME(live2),
    .DEAD_TIME(dead2), .NDROPPED(ndrop2), .NSINGLES(sing2)
  );

  typedef struct {
    int trig; int rd;
    int level; int full; int empty; int ndrop; int ntrig; int vld; int idx;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic assert_reset(input logic ta_hold);
    RESET = 1'b1; TA = ta_hold; LIVE = 1'b0; CLR = 1'b0; rd_en = 1'b0;
    SIG = 2'b00; TS = '0; TL = '0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    logic [81:0] exp_rec;
    exp_rec = {2'b01, 16'd40, 16'd5, 32'd101, 16'd0};

    //          trig rd lvl full empty drop ntrig vld idx
    vt[0]  = '{1, 0, 1, 0, 0, 0, 1,  0, 0};
    vt[1]  = '{1, 0, 2, 0, 0, 0, 2,  0, 0};
    vt[2]  = '{1, 0, 3, 0, 0, 0, 3,  0, 0};
    vt[3]  = '{1, 0, 4, 1, 0, 0, 4,  0, 0};
    vt[4]  = '{1, 0, 4, 1, 0, 1, 5,  0, 0};
    vt[5]  = '{1, 0, 4, 1, 0, 2, 6,  0, 0};
    vt[6]  = '{1, 1, 4, 1, 0, 2, 7,  1, 0};
    vt[7]  = '{0, 1, 3, 0, 0, 2, 7,  1, 1};
    vt[8]  = '{0, 1, 2, 0, 0, 2, 7,  1, 2};
    vt[9]  = '{0, 1, 1, 0, 0, 2, 7,  1, 3};
    vt[10] = '{0, 1, 0, 0, 1, 2, 7,  1, 6};
    vt[11] = '{0, 1, 0, 0, 1, 2, 7,  0, 0};
    vt[12] = '{1, 0, 1, 0, 0, 2, 8,  0, 0};
    vt[13] = '{1, 1, 1, 0, 0, 2, 9,  1, 7};
    vt[14] = '{1, 0, 2, 0, 0, 2, 10, 0, 0};
    vt[15] = '{1, 0, 3, 0, 0, 2, 11, 0, 0};

    // Reset state
    assert_reset(1'b0);
    chk("rst_empty", 128'(rd1.EMPTY), 128'(1));
    chk("rst_full", 128'(rd1.FULL), 128'(0));
    chk("rst_level", 128'(rd1.LEVEL), 128'(0));
    chk("rst_rd_valid", 128'(rd1.RD_VALID), 128'(0));
    chk("rst_rd_data", 128'(rd1.RD_DATA), 128'(0));
    chk("rst_counters", 128'({ntrig1, live1, dead1, ndrop1}), 128'(0));
    chk("rst_singles", 128'(sing1), 128'(0));

    // Single trigger, TRIGGER_ACTIVE rising while the timestamp reads 100
    RESET = 1'b0;
    repeat (100) @(negedge CLK);
    TA = 1'b1; SIG = 2'b01; TS = 16'd5; TL = 16'd40;
    repeat (2) @(negedge CLK);
    chk("single_level", 128'(rd1.LEVEL), 128'(1));
    chk("single_empty", 128'(rd1.EMPTY), 128'(0));
    chk("single_ntrig", 128'(ntrig1), 128'(1));
    chk("single_dead", 128'(dead1), 128'(102));
    chk("single_singles", 128'(sing1), 128'(1));
    TA = 1'b0; rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    chk("single_rd_valid", 128'(rd1.RD_VALID), 128'(1));
    chk("single_record", 128'(rd1.RD_DATA), 128'(exp_rec));
    chk("single_drained", 128'(rd1.EMPTY), 128'(1));
    @(negedge CLK);
    chk("single_valid_pulse", 128'(rd1.RD_VALID), 128'(0));
    chk("single_data_hold", 128'(rd1.RD_DATA), 128'(exp_rec));
    SIG = 2'b00;

    // Overflow, full-with-read, drain and empty-read vectors
    assert_reset(1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 16; i++) begin
      TA = (vt[i].trig != 0); rd_en = 1'b0;
      @(negedge CLK);
      TA = 1'b0; rd_en = (vt[i].rd != 0);
      @(negedge CLK);
      rd_en = 1'b0;
      chk($sformatf("v%0d_level", i), 128'(rd1.LEVEL), 128'(vt[i].level));
      chk($sformatf("v%0d_full", i), 128'(rd1.FULL), 128'(vt[i].full));
      chk($sformatf("v%0d_empty", i), 128'(rd1.EMPTY), 128'(vt[i].empty));
      chk($sformatf("v%0d_ndropped", i), 128'(ndrop1), 128'(vt[i].ndrop));
      chk($sformatf("v%0d_ntriggers", i), 128'(ntrig1), 128'(vt[i].ntrig));
      chk($sformatf("v%0d_rd_valid", i), 128'(rd1.RD_VALID), 128'(vt[i].vld));
      if (vt[i].vld != 0)
        chk($sformatf("v%0d_index", i), 128'(rd1.RD_DATA[15:0]), 128'(vt[i].idx));
    end

    // Reset with three stored records and TRIGGER_ACTIVE held high across release
    assert_reset(1'b1);
    chk("mid_rst_empty", 128'(rd1.EMPTY), 128'(1));
    chk("mid_rst_level", 128'(rd1.LEVEL), 128'(0));
    chk("mid_rst_ndropped", 128'(ndrop1), 128'(0));
    chk("mid_rst_rd_data", 128'(rd1.RD_DATA), 128'(0));
    RESET = 1'b0; rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    chk("mid_rst_empty_read", 128'(rd1.RD_VALID), 128'(0));
    chk("mid_rst_level_pre", 128'(rd1.LEVEL), 128'(0));
    @(negedge CLK);
    chk("release_strobe_level", 128'(rd1.LEVEL), 128'(1));
    TA = 1'b0; rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    chk("release_rd_valid", 128'(rd1.RD_VALID), 128'(1));
    chk("release_index", 128'(rd1.RD_DATA[15:0]), 128'(0));
    chk("release_ntrig", 128'(ntrig1), 128'(1));

    // Saturation of 4-bit counters and 4-bit timestamp wrap
    assert_reset(1'b0);
    RESET = 1'b0; LIVE = 1'b1;
    repeat (19) @(negedge CLK);
    TA = 1'b1;
    @(negedge CLK);
    TA = 1'b0;
    @(negedge CLK);
    chk("sat_live2", 128'(live2), 128'(15));
    chk("sat_dead2", 128'(dead2), 128'(0));
    chk("sat_ntrig2", 128'(ntrig2), 128'(1));
    chk("sat_live1", 128'(live1), 128'(21));
    chk("sat_level2", 128'(rd2.LEVEL), 128'(1));
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    chk("wrap_rd_valid2", 128'(rd2.RD_VALID), 128'(1));
    chk("wrap_ts2", 128'(rd2.RD_DATA[19:16]), 128'(4));
    chk("wrap_ts1", 128'(rd1.RD_DATA[47:16]), 128'(20));

    // Clear, singles counting, clear coincident with a rising edge
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_live", 128'(live1), 128'(0));
    chk("clr_ntrig", 128'(ntrig1), 128'(0));
    chk("clr_singles", 128'(sing1), 128'(0));
    LIVE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      SIG[1] = 1'b1; @(negedge CLK);
      SIG[1] = 1'b0; @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      SIG[0] = 1'b1; @(negedge CLK);
      SIG[0] = 1'b0; @(negedge CLK);
    end
    chk("singles_count", 128'(sing1), 128'({32'd10, 32'd3}));
    chk("singles_count2", 128'(sing2), 128'(8'hA3));
    SIG = 2'b10; CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_edge_singles", 128'(sing1), 128'(0));
    chk("clr_edge_dead", 128'(dead1), 128'(0));
    chk("clr_edge_singles2", 128'(sing2), 128'(0));
    SIG = 2'b00;
    @(negedge CLK);
    SIG = 2'b01;
    @(negedge CLK);
    SIG = 2'b00;
    @(negedge CLK);
    chk("post_clr_single", 128'(sing1), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
